// File: rtl/alu_dec_pkg.sv
// alu_dec_pkg -- shared opcode / control encodings and the combinational
// instruction decoder for the ALU decode stage.
package alu_dec_pkg;

  // Opcodes in instr[15:12]
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_DEC  = 4'h2;
  localparam logic [3:0] OP_INC  = 4'h3;
  localparam logic [3:0] OP_MOV  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_NAND = 4'h9;
  localparam logic [3:0] OP_MULL = 4'hA;
  localparam logic [3:0] OP_MULH = 4'hB;
  localparam logic [3:0] OP_SHL  = 4'hC;
  localparam logic [3:0] OP_SHR  = 4'hD;
  localparam logic [3:0] OP_ADDI = 4'hE;
  localparam logic [3:0] OP_SYS  = 4'hF;

  // ALU unit select
  localparam logic [1:0] ALU_ARITH = 2'b00;
  localparam logic [1:0] ALU_LOGIC = 2'b01;
  localparam logic [1:0] ALU_MUL   = 2'b10;
  localparam logic [1:0] ALU_SHIFT = 2'b11;

  // Function codes within a unit
  localparam logic [1:0] S_ADD  = 2'b00;
  localparam logic [1:0] S_SUB  = 2'b01;
  localparam logic [1:0] S_DEC  = 2'b10;
  localparam logic [1:0] S_INC  = 2'b11;
  localparam logic [1:0] S_MOV  = 2'b01;
  localparam logic [1:0] S_AND  = 2'b00;
  localparam logic [1:0] S_OR   = 2'b01;
  localparam logic [1:0] S_XOR  = 2'b10;
  localparam logic [1:0] S_NOT  = 2'b11;
  localparam logic [1:0] S_NAND = 2'b00;
  localparam logic [1:0] S_NONE = 2'b00;

  // Multiplier half select
  localparam logic [1:0] MUL_NONE = 2'b00;
  localparam logic [1:0] MUL_LO   = 2'b01;
  localparam logic [1:0] MUL_HI   = 2'b10;

  typedef struct packed {
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [2:0]  rd;
    logic        rd_we;
    logic [1:0]  alu_sel;
    logic [1:0]  s;
    logic        sel;
    logic [1:0]  mul;
    logic        use_imm;
    logic [15:0] imm;
    logic        illegal;
  } dec_t;

  // Full control decode; fields an opcode does not use stay 0.
  function automatic dec_t decode_instr(input logic [15:0] instr);
    dec_t d;
    d         = '0;
    d.rs1     = instr[8:6];
    d.rs2     = instr[5:3];
    d.rd      = instr[11:9];
    d.imm     = {{10{instr[5]}}, instr[5:0]};
    d.rd_we   = 1'b1;
    case (instr[15:12])
      OP_ADD:  begin d.alu_sel = ALU_ARITH; d.s = S_ADD; end
      OP_SUB:  begin d.alu_sel = ALU_ARITH; d.s = S_SUB; end
      OP_DEC:  begin d.alu_sel = ALU_ARITH; d.s = S_DEC; end
      OP_INC:  begin d.alu_sel = ALU_ARITH; d.s = S_INC; end
      OP_MOV:  begin d.alu_sel = ALU_MUL;   d.s = S_MOV; end
      OP_AND:  begin d.alu_sel = ALU_LOGIC; d.s = S_AND; end
      OP_OR:   begin d.alu_sel = ALU_LOGIC; d.s = S_OR;  end
      OP_XOR:  begin d.alu_sel = ALU_LOGIC; d.s = S_XOR; end
      OP_NOT:  begin d.alu_sel = ALU_LOGIC; d.s = S_NOT;  d.sel = 1'b1; end
      OP_NAND: begin d.alu_sel = ALU_LOGIC; d.s = S_NAND; d.sel = 1'b1; end
      OP_MULL: begin d.alu_sel = ALU_MUL;   d.s = S_NONE; d.mul = MUL_LO; end
      OP_MULH: begin d.alu_sel = ALU_MUL;   d.s = S_NONE; d.mul = MUL_HI; end
      OP_SHL:  begin d.alu_sel = ALU_SHIFT; d.sel = 1'b0; end
      OP_SHR:  begin d.alu_sel = ALU_SHIFT; d.sel = 1'b1; end
      OP_ADDI: begin d.alu_sel = ALU_ARITH; d.s = S_ADD; d.use_imm = 1'b1; end
      default: begin
        // OP_SYS: all-zero payload is a NOP, anything else is illegal
        d.rd_we   = 1'b0;
        d.illegal = (instr[11:0] != 12'h000);
      end
    endcase
    return d;
  endfunction

  // Which source registers an opcode actually reads: {rs2_read, rs1_read}
  function automatic logic [1:0] src_reads(input logic [15:0] instr);
    logic [1:0] r;
    r = 2'b00;
    if (instr[15:12] != OP_SYS) r[0] = 1'b1;
    case (instr[15:12])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NAND,
      OP_MULL, OP_MULH, OP_SHL, OP_SHR: r[1] = 1'b1;
      default:                          r[1] = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_dec_scoreboard.sv
// alu_dec_scoreboard -- 8-entry pending-write scoreboard. Sets win over
// same-cycle clears; clears show up on o_pending one cycle later.
module alu_dec_scoreboard
  import alu_dec_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_set,
  input  logic [2:0] i_set_idx,
  input  logic       i_clr,
  input  logic [2:0] i_clr_idx,
  input  logic       i_fclr,
  input  logic [2:0] i_fclr_idx,
  output logic [7:0] o_pending
);

  logic [7:0] r_pending;
  logic [7:0] w_set_mask;
  logic [7:0] w_clr_mask;

  // Build one-hot set/clear masks for this cycle
  always_comb begin
    w_set_mask = 8'd0;
    w_clr_mask = 8'd0;
    if (i_set)  w_set_mask = 8'd1 << i_set_idx;
    if (i_clr)  w_clr_mask = w_clr_mask | (8'd1 << i_clr_idx);
    if (i_fclr) w_clr_mask = w_clr_mask | (8'd1 << i_fclr_idx);
  end

  // Pending register: clear first, then set, so a same-bit collision stays set
  always_ff @(posedge clk) begin
    if (rst) r_pending <= 8'd0;
    else     r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage -- single-register decode stage between fetch and execute.
// Optional build macro ALU_DEC_HAZARD_EN adds the pending-register scoreboard
// and stalls instructions whose sources or destination are still in flight.
module alu_decode_stage
  import alu_dec_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  rs1_addr,
  output logic [2:0]  rs2_addr,
  output logic [2:0]  rd_addr,
  output logic        rd_we,
  output logic [1:0]  alu_sel,
  output logic [1:0]  s,
  output logic        sel,
  output logic [1:0]  mul,
  output logic        use_imm,
  output logic [15:0] imm,
  output logic        illegal,
  input  logic        wb_valid,
  input  logic [2:0]  wb_rd,
  input  logic        flush
);

  dec_t       w_dec;
  logic [1:0] w_reads;
  logic       w_hazard;
  logic       w_accept;
  dec_t       r_dec;
  logic       r_out_valid;

  // Combinational decode of the incoming instruction
  always_comb begin
    w_dec   = decode_instr(instr);
    w_reads = src_reads(instr);
  end

  assign in_ready = (~r_out_valid | out_ready) & ~w_hazard & ~flush;
  assign w_accept = in_valid & in_ready;

`ifdef ALU_DEC_HAZARD_EN
  logic [7:0] w_pending;

  alu_dec_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_set      (w_accept & w_dec.rd_we),
    .i_set_idx  (w_dec.rd),
    .i_clr      (wb_valid),
    .i_clr_idx  (wb_rd),
    .i_fclr     (flush & r_out_valid & r_dec.rd_we),
    .i_fclr_idx (r_dec.rd),
    .o_pending  (w_pending)
  );

  // RAW on sources actually read, WAW on the destination
  assign w_hazard = (w_reads[0]  & w_pending[w_dec.rs1]) |
                    (w_reads[1]  & w_pending[w_dec.rs2]) |
                    (w_dec.rd_we & w_pending[w_dec.rd]);
`else
  logic w_unused;
  assign w_hazard = 1'b0;
  assign w_unused = ^{wb_valid, wb_rd, w_reads};
`endif

  // Output register: flush beats accept, accept beats drain; data only loads on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_dec       <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_dec       <= w_dec;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign rs1_addr  = r_dec.rs1;
  assign rs2_addr  = r_dec.rs2;
  assign rd_addr   = r_dec.rd;
  assign rd_we     = r_dec.rd_we;
  assign alu_sel   = r_dec.alu_sel;
  assign s         = r_dec.s;
  assign sel       = r_dec.sel;
  assign mul       = r_dec.mul;
  assign use_imm   = r_dec.use_imm;
  assign imm       = r_dec.imm;
  assign illegal   = r_dec.illegal;

endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: in_valid in 1 / in_ready out 1 / instr in 16  instruction handshake from fetch.
REQ-004 SHALL have ports: out_valid out 1 / out_ready in 1  decoded-bundle handshake to execute.
REQ-005 SHALL have ports: rs1_addr, rs2_addr, rd_addr  out  3 each  register indices (instr[8:6], [5:3], [11:9]).
REQ-006 SHALL have ports: rd_we out 1; alu_sel out 2; s out 2; sel out 1; mul out 2  ALU control.
REQ-007 SHALL have ports: use_imm out 1; imm out 16  (sign-extended instr[5:0]); illegal out 1.
REQ-008 SHALL have ports: wb_valid in 1 / wb_rd in 3  writeback retire; flush in 1  kill held/incoming instruction.

Function
REQ-009 SHALL decode opcode instr[15:12]: 0 ADD{00,s00}, 1 SUB{00,s01}, 2 DEC{00,s10}, 3 INC{00,s11}, 4 MOV{10,s01}.
REQ-010 SHALL decode: 5 AND{01,s00,sel0}, 6 OR{01,s01,sel0}, 7 XOR{01,s10,sel0}, 8 NOT{01,s11,sel1}, 9 NAND{01,s00,sel1}.
REQ-011 SHALL decode: A MULL{10,s00,mul01}, B MULH{10,s00,mul10}, C SHL{11,sel0}, D SHR{11,sel1}, E ADDI{00,s00,use_imm=1}.
REQ-012 SHALL treat F with instr[11:0]==0 as NOP (rd_we=0); F otherwise illegal=1, rd_we=0; unused control fields drive 0; mul=00 for non-multiply.
REQ-013 SHALL never emit alu_sel=10 with s=01 except for MOV.
REQ-014 SHALL register all outputs; accepted instruction appears with out_valid=1 exactly one cycle after in_valid&in_ready.
REQ-015 SHALL drive in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
REQ-016 SHALL hold all outputs stable while out_valid & ~out_ready.
REQ-017 SHALL keep out_valid=0 after a transfer when no new instruction is accepted (no bubble duplication).
REQ-018 SHALL on flush: out_valid=0 next cycle, incoming instruction not accepted; flush has priority over all else.
REQ-019 SHALL keep 8-bit pending scoreboard: set bit rd_addr on accept with rd_we=1; clear bit wb_rd on wb_valid.
REQ-020 SHALL, on same-cycle set and clear of same bit, leave bit set; clears become visible next cycle (no bypass).
REQ-021 SHALL on flush clear pending bit of the held instruction if out_valid&rd_we; other bits unaffected.
REQ-022 SHALL assert hazard when any source actually read (rs1 all ops except NOP/illegal; rs2 for ADD,SUB,AND,OR,XOR,NAND,MUL*,SH*) or rd (WAW) is pending.

Reset
REQ-023 SHALL on rst: out_valid=0, scoreboard=0, all registered outputs 0, in_ready=1 the cycle after rst deasserts.
REQ-024 SHALL let rst mid-transfer discard the held instruction without output.

Configuration
REQ-025 SHALL compile scoreboard and hazard stall only when ALU_DEC_HAZARD_EN is defined.
REQ-026 SHALL, without ALU_DEC_HAZARD_EN, tie hazard=0, ignore wb_valid/wb_rd, omit scoreboard; all else identical.

Structure
REQ-027 SHALL place opcode constants, alu_sel codes (ARITH=00, LOGIC=01, MUL=10, SHIFT=11) and s/mul codes in package alu_dec_pkg.
REQ-028 SHALL implement scoreboard as sub-module alu_dec_scoreboard (set/clear/flush-clear, 8-bit pending out).
REQ-029 SHALL keep decode purely combinational feeding one output register stage.

Verification
REQ-030 SHALL cover: instr 0x0A98 (ADD r5,r2,r3), out_ready=1 -> next cycle out_valid=1, alu_sel=00, s=00, rd_addr=5, rd_we=1.
REQ-031 SHALL cover: ADDI 0xE23F -> use_imm=1, imm=0xFFFF; MOV 0x4280 -> alu_sel=10, s=01; MULH -> mul=10, s=00.
REQ-032 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged, single transfer when released.
REQ-033 SHALL cover (HAZARD_EN): ADD r1 then SUB reading r1 -> in_ready=0 until wb_valid,wb_rd=1; accepted cycle after clear.
REQ-034 SHALL cover: flush while held ADD r4 pending -> out_valid=0 next cycle, pending[4]=0, no output emitted.
REQ-035 SHALL cover: 0xF001 -> illegal=1, rd_we=0; rst asserted with out_valid=1 -> out_valid=0, scoreboard=0.
